procesador_multiciclo: RTL and testbench
========================================

PROCESADOR_MULTICICLO -- requirements
Module: procesador_multiciclo

Interface
REQ-001 Parameter DW, default 32, datapath and register width; SHALL be 32 or 64.
REQ-002 Parameter AW, default 8, PC and memory byte-address width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port mem_req  output  1  memory request valid.
REQ-007 Port mem_we  output  1  1 = store, 0 = load or fetch; meaningful only while mem_req is high.
REQ-008 Port mem_addr  output  AW  byte address.
REQ-009 Port mem_wdata  output  DW  store data.
REQ-010 Port mem_rdata  input  DW  fetch or load data, valid in the cycle mem_ack is high.
REQ-011 Port mem_ack  input  1  memory completion strobe.
REQ-012 Port halted  output  1  core stopped on an illegal opcode.
REQ-013 Port pc_dbg  output  AW  current PC.

Function
REQ-014 The core SHALL execute 32-bit MIPS-encoded instructions over a unified memory port using FSM states FETCH, DECODE, EXEC, MEMACC, WB and HALT.
REQ-015 FETCH SHALL hold mem_req=1, mem_we=0 and mem_addr=PC.
  - On mem_ack: latch mem_rdata[31:0] into IR, set PC=PC+4 mod 2^AW, go to DECODE.
REQ-016 DECODE SHALL read rs and rt into A and B, and compute branch target PC + (sext(imm)<<2) truncated to AW.
  - Illegal opcode goes to HALT.
REQ-017 Supported opcodes:
  - R-type 0x00 with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed);
  - ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - An unknown funct SHALL be treated as illegal.
REQ-018 EXEC rules:
  - ALU arithmetic SHALL be DW-bit modulo 2^DW; immediates are sign-extended to DW.
  - BEQ: load the target if A==B, then go to FETCH.
  - J: PC = {PC[AW-1:28] where present, IR[25:0]<<2} truncated to AW, then go to FETCH.
  - LW and SW go to MEMACC; R-type and ADDI go to WB.
REQ-019 MEMACC SHALL hold mem_req=1, mem_addr=ALU result[AW-1:0], and mem_we=1 (with mem_wdata=B) for SW.
  - On mem_ack, SW goes to FETCH and LW latches mem_rdata into MDR and goes to WB.
REQ-020 WB SHALL write the register file in one cycle, then go to FETCH.
  - Destination is rd for R-type, rt for ADDI and LW.
  - Written data is the ALU result, or MDR for LW.
REQ-021 Register 0 SHALL read as 0; writes to it SHALL be discarded.
REQ-022 mem_req SHALL stay high and mem_addr, mem_we and mem_wdata SHALL stay stable from request until the mem_ack cycle.
  - mem_req SHALL drop in the cycle after mem_ack.
  - mem_ack while mem_req is low SHALL be ignored.
REQ-023 Latency with zero-wait memory (ack in the first request cycle):
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ and J: 3 cycles.
REQ-024 HALT SHALL be terminal until reset.
  - halted=1, mem_req=0, PC frozen.
REQ-025 PC wrap-around past 2^AW-4 SHALL wrap to 0 with no error.

Reset
REQ-026 While rst_n=0, outputs SHALL be: state=FETCH, PC=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, pc_dbg=RESET_PC.
REQ-027 Register file contents SHALL be cleared to 0 on reset.
REQ-028 Reset asserted mid-transaction SHALL abort it immediately with no register write.
REQ-029 The first mem_req SHALL assert in the first clock edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold the state enumeration, opcode and funct constants, and the ALU operation encoding.
REQ-031 The register file SHALL be one sub-module, banco_reg_param (parameter DW, 32 entries, two asynchronous read ports, one synchronous write port, asynchronous reset).
REQ-032 The FSM, ALU and PC logic SHALL reside in the top module.

Verification
REQ-033 ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2 with zero-wait memory -> $3=2, 12 cycles total.
REQ-034 SW $3,16($0) then LW $4,16($0), with ack delayed 3 cycles -> store seen with mem_addr=16, mem_wdata=2, stable through ack; $4=2.
REQ-035 BEQ $1,$1,+2 at PC 8 -> next fetch address 20; BEQ $1,$2 (unequal) -> next fetch 12.
REQ-036 ADDI $0,$0,7 then SLT $5,$2,$1 -> $0 reads 0; $5=1 (signed -3<5).
REQ-037 Opcode 0x3F fetched -> halted=1 after DECODE, mem_req stays 0 for 20 cycles.
REQ-038 rst_n pulsed low during a MEMACC wait -> mem_req=0 asynchronously, PC=RESET_PC, registers 0, next fetch at RESET_PC.

Source files
------------

// File: rtl/procesador_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: FSM states,
// opcode/funct encodings and ALU operation selector.
package procesador_multiciclo_pkg;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMACC, WB, HALT} state_t;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   function automatic logic es_legal(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/banco_reg_param.sv
// 32-entry register file: two combinational read ports, one clocked write
// port; entry 0 is hardwired to zero.
module banco_reg_param #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [4:0]    ra1,
   input  logic [4:0]    ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [4:0]    wa,
   input  logic [DW-1:0] wd
);

   logic [31:0][DW-1:0] regs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 regs     <= '0;
      else if (we && wa != 5'd0)  regs[wa] <= wd;
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/procesador_multiciclo.sv
// Multicycle MIPS-subset core on a single unified request/ack memory port.
// FSM, ALU and PC logic live here; the register file is a sub-module.
module procesador_multiciclo
   import procesador_multiciclo_pkg::*;
#(
   parameter int            DW       = 32,
   parameter int            AW       = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          halted,
   output logic [AW-1:0] pc_dbg
);

   state_t        state, state_nx;
   logic          run;
   logic [AW-1:0] pc, target, jt;
   logic [31:0]   ir;
   logic [DW-1:0] a, b, aluout, mdr;
   logic [DW-1:0] rd1, rd2, simm, opb, alu_y;
   alu_op_t       aop;

   wire [5:0]  op  = ir[31:26];
   wire [4:0]  rs  = ir[25:21];
   wire [4:0]  rt  = ir[20:16];
   wire [4:0]  rd  = ir[15:11];
   wire [15:0] imm = ir[15:0];

   assign simm = {{(DW-16){imm[15]}}, imm};

   banco_reg_param #(.DW(DW)) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (state == WB),
      .wa    ((op == OP_RTYPE) ? rd : rt),
      .wd    ((op == OP_LW) ? mdr : aluout)
   );

   always_comb begin
      aop = ALU_ADD;
      if (op == OP_RTYPE) begin
         case (imm[5:0])
            FN_SUB:  aop = ALU_SUB;
            FN_AND:  aop = ALU_AND;
            FN_OR:   aop = ALU_OR;
            FN_SLT:  aop = ALU_SLT;
            default: aop = ALU_ADD;
         endcase
      end
      opb = (op == OP_RTYPE) ? b : simm;
      case (aop)
         ALU_SUB: alu_y = a - opb;
         ALU_AND: alu_y = a & opb;
         ALU_OR:  alu_y = a | opb;
         ALU_SLT: alu_y = {{(DW-1){1'b0}}, ($signed(a) < $signed(opb))};
         default: alu_y = a + opb;
      endcase
   end

   // Jump keeps PC bits above 27 (only present when AW > 28).
   assign jt = (pc & ~AW'(28'hFFF_FFFF)) | AW'({ir[25:0], 2'b00});

   always_comb begin
      state_nx = state;
      case (state)
         FETCH:  if (run && mem_ack) state_nx = DECODE;
         DECODE: state_nx = es_legal(op, imm[5:0]) ? EXEC : HALT;
         EXEC: begin
            case (op)
               OP_BEQ, OP_J: state_nx = FETCH;
               OP_LW, OP_SW: state_nx = MEMACC;
               default:      state_nx = WB;
            endcase
         end
         MEMACC: if (mem_ack) state_nx = (op == OP_SW) ? FETCH : WB;
         WB:     state_nx = FETCH;
         HALT:   state_nx = HALT;
         default: state_nx = FETCH;
      endcase
   end

   // run holds the port quiet for the reset cycle so the first request
   // appears on the first edge after rst_n releases.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (run && state == FETCH) begin
         mem_req  = 1'b1;
         mem_addr = pc;
      end else if (run && state == MEMACC) begin
         mem_req  = 1'b1;
         mem_addr = AW'(aluout);
         if (op == OP_SW) begin
            mem_we    = 1'b1;
            mem_wdata = b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FETCH;
         run    <= 1'b0;
         pc     <= RESET_PC;
         target <= '0;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         aluout <= '0;
         mdr    <= '0;
      end else begin
         run   <= 1'b1;
         state <= state_nx;
         case (state)
            FETCH: if (run && mem_ack) begin
               ir <= mem_rdata[31:0];
               pc <= pc + AW'(4);
            end
            DECODE: begin
               a      <= rd1;
               b      <= rd2;
               target <= pc + AW'(simm << 2);
            end
            EXEC: begin
               aluout <= alu_y;
               if (op == OP_BEQ && a == b) pc <= target;
               if (op == OP_J)             pc <= jt;
            end
            MEMACC: if (mem_ack && op == OP_LW) mdr <= mem_rdata;
            default: ;
         endcase
      end
   end

   assign halted = (state == HALT);
   assign pc_dbg = pc;

endmodule

// File: tb/tb_procesador_multiciclo.sv
// Bench for procesador_multiciclo: behavioural memory with programmable wait
// states, directed scenarios and random programs checked against an ISA model.
module tb_procesador_multiciclo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we, halted;
   logic [7:0]  mem_addr, pc_dbg;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   procesador_multiciclo #(.DW(32), .AW(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .halted(halted), .pc_dbg(pc_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {bit we; int addr; logic [31:0] data; int cyc;} acc_t;

   int errors = 0, checks = 0;
   int lat = 0, cyc = 0, wcnt = 0, stab_viol = 0;
   logic [31:0] mem [0:63];
   logic [31:0] mm  [0:63];
   acc_t log_q[$];
   acc_t exp_q[$];
   logic [7:0]  s_addr;
   logic        s_we;
   logic [31:0] s_wd;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: acks after `lat` wait cycles, logs every completed access and
   // counts any change of address/direction/data while a request is pending.
   always @(negedge clk) begin
      acc_t e;
      if (mem_ack) wcnt = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
         if (wcnt == 0) begin
            s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
         end else if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wd)
            stab_viol++;
         if (wcnt >= lat) begin
            mem_ack = 1'b1;
            e.we = mem_we; e.addr = int'(mem_addr); e.cyc = cyc;
            if (mem_we) begin
               e.data = mem_wdata;
               mem[mem_addr[7:2]] = mem_wdata;
            end else begin
               e.data = mem[mem_addr[7:2]];
               mem_rdata = mem[mem_addr[7:2]];
            end
            log_q.push_back(e);
         end
         wcnt++;
      end else wcnt = 0;
   end

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
   endfunction
   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(int tgt);
      return {6'h02, 26'(tgt)};
   endfunction

   task automatic load_prog(input logic [31:0] p[$]);
      for (int i = 0; i < 64; i++) mem[i] = '0;
      foreach (p[i]) mem[i] = p[i];
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      log_q.delete();
      stab_viol = 0;
      rst_n = 1'b1;
   endtask

   task automatic wait_acc(input int n, input int budget);
      for (int k = 0; k < budget && log_q.size() < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   // Instruction-level model: walks the program image, emitting the expected
   // access stream with ack times; stops on a self-jump or illegal instruction.
   task automatic model_run(input int max_steps, input int l);
      logic [31:0] r [32];
      logic [31:0] w, a, b, res, simm;
      int pc, npc, t, ea;
      bit done, wr;
      acc_t e;
      for (int i = 0; i < 32; i++) r[i] = '0;
      pc = 0; t = 0; done = 0;
      exp_q.delete();
      for (int s = 0; s < max_steps && !done; s++) begin
         w = mm[pc / 4];
         a = r[w[25:21]]; b = r[w[20:16]];
         simm = {{16{w[15]}}, w[15:0]};
         e.we = 0; e.addr = pc; e.data = w; e.cyc = t + l;
         exp_q.push_back(e);
         npc = (pc + 4) % 256;
         wr = 0; res = '0;
         case (w[31:26])
            6'h00: begin
               wr = 1;
               case (w[5:0])
                  6'h20: res = a + b;
                  6'h22: res = a - b;
                  6'h24: res = a & b;
                  6'h25: res = a | b;
                  6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: begin wr = 0; done = 1; end
               endcase
               if (wr && w[15:11] != 0) r[w[15:11]] = res;
               t += 4 + l;
            end
            6'h08: begin
               if (w[20:16] != 0) r[w[20:16]] = a + simm;
               t += 4 + l;
            end
            6'h23: begin
               ea = int'((a + simm) & 32'hFF);
               e.we = 0; e.addr = ea; e.data = mm[ea / 4]; e.cyc = t + 2 * l + 3;
               exp_q.push_back(e);
               if (w[20:16] != 0) r[w[20:16]] = mm[ea / 4];
               t += 5 + 2 * l;
            end
            6'h2B: begin
               ea = int'((a + simm) & 32'hFF);
               e.we = 1; e.addr = ea; e.data = b; e.cyc = t + 2 * l + 3;
               exp_q.push_back(e);
               mm[ea / 4] = b;
               t += 4 + 2 * l;
            end
            6'h04: begin
               if (a == b) npc = int'((npc + (simm << 2)) & 32'hFF);
               t += 3 + l;
            end
            6'h02: begin
               npc = int'({w[25:0], 2'b00} & 28'hFF);
               if (npc == pc) done = 1;
               t += 3 + l;
            end
            default: done = 1;
         endcase
         pc = npc;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 64; i++) mem[i] = '0;
      @(posedge clk); #3;
      checks++; if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 8'h00)  begin errors++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
      checks++; if (mem_wdata !== '0)    begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
      checks++; if (pc_dbg !== 8'h00)    begin errors++; $display("FAIL rst_pc: got %h want 00", pc_dbg); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rel_req_early: got %b want 0", mem_req); end
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
         errors++; $display("FAIL first_fetch: req=%b addr=%h we=%b want 1/00/0", mem_req, mem_addr, mem_we);
      end
   endtask

   task automatic test_arith();
      logic [31:0] p[$];
      p = '{enc_i(8,0,1,5), enc_i(8,0,2,-3), enc_r(1,2,3,32'h20), enc_i(8,0,0,7),
            enc_r(2,1,5,32'h2A), enc_i(8'h2B,0,3,64), enc_i(8'h2B,0,5,68),
            enc_i(8'h2B,0,0,72), enc_j(8)};
      load_prog(p);
      lat = 0;
      do_reset();
      wait_acc(12, 200);
      checks++;
      if (log_q.size() < 12) begin
         errors++; $display("FAIL arith_timeout: got %0d accesses want 12", log_q.size());
      end else begin
         checks++;
         if (log_q[3].addr != 12 || log_q[3].cyc - log_q[0].cyc != 12) begin
            errors++; $display("FAIL arith_12cyc: fetch %0d at +%0d want 12 at +12", log_q[3].addr, log_q[3].cyc - log_q[0].cyc);
         end
         checks++;
         if (!log_q[6].we || log_q[6].addr != 64 || log_q[6].data !== 32'd2) begin
            errors++; $display("FAIL add_result: we=%0d addr=%0d data=%0h want 1/64/2", log_q[6].we, log_q[6].addr, log_q[6].data);
         end
         checks++;
         if (!log_q[8].we || log_q[8].data !== 32'd1) begin
            errors++; $display("FAIL slt_signed: data=%0h want 1", log_q[8].data);
         end
         checks++;
         if (!log_q[10].we || log_q[10].data !== 32'd0) begin
            errors++; $display("FAIL r0_zero: data=%0h want 0", log_q[10].data);
         end
         checks++;
         if (log_q[7].cyc - log_q[5].cyc != 4) begin
            errors++; $display("FAIL sw_latency: got %0d want 4", log_q[7].cyc - log_q[5].cyc);
         end
      end
   endtask

   task automatic test_mem_wait();
      logic [31:0] p[$];
      p = '{enc_i(8,0,3,2), enc_j(6), 32'h0, 32'h0, 32'h0, 32'h0,
            enc_i(8'h2B,0,3,16), enc_i(8'h23,0,4,16), enc_i(8'h2B,0,4,20), enc_j(9)};
      load_prog(p);
      lat = 3;
      do_reset();
      wait_acc(9, 400);
      checks++;
      if (log_q.size() < 9) begin
         errors++; $display("FAIL mem_timeout: got %0d accesses want 9", log_q.size());
      end else begin
         checks++;
         if (!log_q[3].we || log_q[3].addr != 16 || log_q[3].data !== 32'd2) begin
            errors++; $display("FAIL sw_wait: we=%0d addr=%0d data=%0h want 1/16/2", log_q[3].we, log_q[3].addr, log_q[3].data);
         end
         checks++;
         if (log_q[5].we || log_q[5].addr != 16) begin
            errors++; $display("FAIL lw_addr: we=%0d addr=%0d want 0/16", log_q[5].we, log_q[5].addr);
         end
         checks++;
         if (!log_q[7].we || log_q[7].addr != 20 || log_q[7].data !== 32'd2) begin
            errors++; $display("FAIL lw_value: addr=%0d data=%0h want 20/2", log_q[7].addr, log_q[7].data);
         end
         checks++;
         if (log_q[6].cyc - log_q[4].cyc != 11) begin
            errors++; $display("FAIL lw_latency_wait: got %0d want 11", log_q[6].cyc - log_q[4].cyc);
         end
      end
      checks++;
      if (stab_viol != 0) begin errors++; $display("FAIL req_stable: got %0d changes want 0", stab_viol); end
   endtask

   task automatic test_branch();
      logic [31:0] p[$];
      p = '{enc_i(8,0,1,5), enc_i(8,0,2,-3), enc_i(4,1,1,2), 32'h0, 32'h0, enc_j(5)};
      load_prog(p);
      lat = 0;
      do_reset();
      wait_acc(4, 100);
      checks++;
      if (log_q.size() < 4 || log_q[3].addr != 20 || log_q[3].cyc - log_q[2].cyc != 3) begin
         errors++; $display("FAIL beq_taken: got %0d accesses, next fetch %0d want 20 after 3 cycles",
                            log_q.size(), log_q.size() >= 4 ? log_q[3].addr : -1);
      end
      p = '{enc_i(8,0,1,5), enc_i(8,0,2,-3), enc_i(4,1,2,2), enc_j(3)};
      load_prog(p);
      do_reset();
      wait_acc(4, 100);
      checks++;
      if (log_q.size() < 4 || log_q[3].addr != 12) begin
         errors++; $display("FAIL beq_not_taken: next fetch %0d want 12", log_q.size() >= 4 ? log_q[3].addr : -1);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] p[$];
      p = '{enc_j(63)};
      load_prog(p);
      mem[63] = enc_i(8,1,1,1);
      lat = 0;
      do_reset();
      wait_acc(3, 100);
      checks++;
      if (log_q.size() < 3 || log_q[1].addr != 252 || log_q[2].addr != 0 || log_q[2].cyc - log_q[0].cyc != 7) begin
         errors++; $display("FAIL pc_wrap: fetches %0d,%0d want 252,0 (size %0d)",
                            log_q.size() >= 2 ? log_q[1].addr : -1, log_q.size() >= 3 ? log_q[2].addr : -1, log_q.size());
      end
   endtask

   task automatic test_halt();
      logic [31:0] p[$];
      int bad;
      p = '{enc_i(8,0,1,1), 32'hFC00_0000};
      load_prog(p);
      lat = 0;
      do_reset();
      wait_acc(2, 100);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0 in DECODE", halted); end
      @(posedge clk); #1;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL halt_terminal: %0d bad cycles want 0", bad); end
      checks++; if (pc_dbg !== 8'd8 || log_q.size() != 2) begin
         errors++; $display("FAIL halt_frozen: pc=%0d accesses=%0d want 8/2", pc_dbg, log_q.size());
      end
      p = '{enc_r(1,2,3,32'h21)};
      load_prog(p);
      do_reset();
      repeat (6) @(posedge clk);
      #1;
      checks++; if (halted !== 1'b1 || log_q.size() != 1) begin
         errors++; $display("FAIL bad_funct: halted=%b accesses=%0d want 1/1", halted, log_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] p[$];
      int k;
      p = '{enc_i(8,0,1,9), enc_i(8'h23,0,2,64)};
      load_prog(p);
      lat = 6;
      do_reset();
      k = 0;
      while (k < 100 && !(mem_req === 1'b1 && mem_addr === 8'd64 && log_q.size() >= 2)) begin
         @(posedge clk); #1; k++;
      end
      checks++; if (k >= 100) begin errors++; $display("FAIL memacc_timeout: no load request seen"); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || pc_dbg !== 8'd0 || mem_addr !== 8'd0) begin
         errors++; $display("FAIL async_abort: req=%b pc=%0d addr=%0d want 0/0/0", mem_req, pc_dbg, mem_addr);
      end
      @(negedge clk);
      p = '{enc_i(8'h2B,0,1,68), enc_j(1)};
      load_prog(p);
      log_q.delete();
      lat = 0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_acc(3, 100);
      checks++;
      if (log_q.size() < 3 || log_q[0].addr != 0 || !log_q[1].we || log_q[1].data !== 32'd0) begin
         errors++; $display("FAIL regs_cleared: accesses=%0d first=%0d stored=%0h want 0 and 0",
                            log_q.size(), log_q.size() > 0 ? log_q[0].addr : -1, log_q.size() > 1 ? log_q[1].data : 32'hx);
      end
   endtask

   task automatic test_random();
      logic [31:0] p[$];
      int fns[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
      int n;
      for (int it = 0; it < 8; it++) begin
         p.delete();
         for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
               0: p.push_back(enc_i(8, $urandom_range(0,7), $urandom_range(1,7), $urandom_range(0,65535)));
               1: p.push_back(enc_r($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), fns[$urandom_range(0,4)]));
               2: p.push_back(enc_i(8'h23, 0, $urandom_range(1,7), 128 + 4 * $urandom_range(0,31)));
               default: p.push_back(enc_i(8'h2B, 0, $urandom_range(0,7), 128 + 4 * $urandom_range(0,31)));
            endcase
         end
         for (int r = 1; r < 8; r++) p.push_back(enc_i(8'h2B, 0, r, 128 + 4 * (r - 1)));
         p.push_back(enc_j(17));
         load_prog(p);
         for (int i = 32; i < 64; i++) mem[i] = $urandom;
         for (int i = 0; i < 64; i++) mm[i] = mem[i];
         lat = $urandom_range(0, 2);
         model_run(100, lat);
         n = exp_q.size();
         do_reset();
         wait_acc(n, 2000);
         checks++;
         if (log_q.size() < n) begin
            errors++; $display("FAIL rand_timeout: iter %0d got %0d accesses want %0d", it, log_q.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (log_q[i].we != exp_q[i].we || log_q[i].addr != exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
                   (log_q[i].cyc - log_q[0].cyc) != (exp_q[i].cyc - exp_q[0].cyc)) begin
                  errors++;
                  $display("FAIL rand_acc: iter %0d idx %0d got we=%0d addr=%0d data=%h t=%0d want we=%0d addr=%0d data=%h t=%0d",
                           it, i, log_q[i].we, log_q[i].addr, log_q[i].data, log_q[i].cyc - log_q[0].cyc,
                           exp_q[i].we, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc - exp_q[0].cyc);
               end
            end
         end
         checks++;
         if (stab_viol != 0) begin errors++; $display("FAIL rand_stable: iter %0d %0d changes", it, stab_viol); end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_mem_wait();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
